// File: rtl/alu_iter.sv
// alu_iter: multi-cycle execute ALU with a start/ready/done handshake.
// Single-cycle ops (MOV ADD SUB SHR SHL XOR AND OR) finish in one cycle.
// MUL (shift-add) and DIV (restoring) iterate one bit per cycle on operand
// magnitudes. A final FIX cycle then applies the signs and computes the flags.
// Results and flags are registered. They update only when done pulses, and
// they hold their value until the next done.

module alu_iter #(
  parameter int W   = 32,
  parameter int SHW = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [3:0]   op,
  input  logic         op_signed,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         ready,
  output logic         done,
  output logic [W-1:0] res_lo,
  output logic [W-1:0] res_hi,
  output logic [3:0]   flags
);

  localparam logic [3:0] CMD_MOV = 4'd0;
  localparam logic [3:0] CMD_ADD = 4'd1;
  localparam logic [3:0] CMD_SUB = 4'd2;
  localparam logic [3:0] CMD_MUL = 4'd3;
  localparam logic [3:0] CMD_DIV = 4'd4;
  localparam logic [3:0] CMD_SHR = 4'd5;
  localparam logic [3:0] CMD_SHL = 4'd6;
  localparam logic [3:0] CMD_XOR = 4'd7;
  localparam logic [3:0] CMD_AND = 4'd8;
  localparam logic [3:0] CMD_OR  = 4'd9;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ITER = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [SHW-1:0] cnt_q, cnt_d;
  logic           is_div_q, is_div_d;   // iterating a DIV (else a MUL)
  logic           sgn_q, sgn_d;         // signed mode latched at accept
  logic           neg_q, neg_d;         // product or quotient must be negated
  logic           rneg_q, rneg_d;       // remainder must be negated
  logic [W-1:0]   hi_q, hi_d;           // MUL: partial-product high; DIV: remainder
  logic [W-1:0]   lo_q, lo_d;           // MUL: multiplier / product low; DIV: dividend / quotient
  logic [W-1:0]   mcand_q, mcand_d;     // MUL multiplicand or DIV divisor magnitude
  logic [W-1:0]   res_lo_q, res_lo_d;
  logic [W-1:0]   res_hi_q, res_hi_d;
  logic [3:0]     flags_q, flags_d;
  logic           done_q, done_d;

  // Single-cycle result path: lo/hi/flags for the ops that finish at accept.
  logic [W-1:0]   sc_lo, sc_hi;
  logic           sc_dz, sc_vf, sc_cf;
  logic [W:0]     add_w, sub_w;
  logic [SHW-1:0] sh_amt;

  assign sh_amt = b[SHW-1:0];
  assign add_w  = {1'b0, a} + {1'b0, b};
  assign sub_w  = {1'b0, a} - {1'b0, b};

  // Combinational result for every op that completes in the accept cycle.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and infers a latch.
    sc_lo = '0;
    sc_hi = '0;
    sc_dz = 1'b0;
    sc_vf = 1'b0;
    sc_cf = 1'b0;
    case (op)
      CMD_MOV: begin
        sc_lo = a;
        sc_hi = b;
      end
      CMD_ADD: begin
        sc_lo = add_w[W-1:0];
        sc_hi = {{(W-1){1'b0}}, add_w[W]};
        sc_cf = add_w[W];
        sc_vf = (a[W-1] == b[W-1]) && (add_w[W-1] != a[W-1]);
      end
      CMD_SUB: begin
        sc_lo = sub_w[W-1:0];
        sc_hi = {W{sub_w[W]}};
        sc_cf = sub_w[W];
        sc_vf = (a[W-1] != b[W-1]) && (sub_w[W-1] != a[W-1]);
      end
      CMD_SHR: begin
        if (op_signed) sc_lo = $signed(a) >>> sh_amt;
        else           sc_lo = a >> sh_amt;
      end
      CMD_SHL: sc_lo = a << sh_amt;
      CMD_XOR: sc_lo = a ^ b;
      CMD_AND: sc_lo = a & b;
      CMD_OR:  sc_lo = a | b;
      CMD_DIV: begin
        // Divide by zero never enters ITER and reports dz instead.
        sc_lo = '1;
        sc_hi = a;
        sc_dz = 1'b1;
      end
      default: begin
        sc_lo = '0;
        sc_hi = '0;
      end
    endcase
  end

  // Working signals for the iterative datapath.
  logic           a_neg, b_neg;
  logic [W-1:0]   mag_a, mag_b;
  logic [W:0]     div_sh, div_diff, mul_add;
  logic [2*W-1:0] prod;
  logic [W-1:0]   quo, rem, ext;
  logic           ovf;

  // FSM next-state logic, iteration step, and result/flag update.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    is_div_d = is_div_q;
    sgn_d    = sgn_q;
    neg_d    = neg_q;
    rneg_d   = rneg_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    mcand_d  = mcand_q;
    res_lo_d = res_lo_q;
    res_hi_d = res_hi_q;
    flags_d  = flags_q;
    done_d   = 1'b0;
    a_neg    = op_signed & a[W-1];
    b_neg    = op_signed & b[W-1];
    mag_a    = a_neg ? -a : a;
    mag_b    = b_neg ? -b : b;
    div_sh   = {hi_q, lo_q[W-1]};
    div_diff = div_sh - {1'b0, mcand_q};
    mul_add  = lo_q[0] ? ({1'b0, hi_q} + {1'b0, mcand_q}) : {1'b0, hi_q};
    prod     = neg_q ? -{hi_q, lo_q} : {hi_q, lo_q};
    quo      = neg_q ? -lo_q : lo_q;
    rem      = rneg_q ? -hi_q : hi_q;
    ext      = sgn_q ? {W{prod[W-1]}} : '0;
    ovf      = (prod[2*W-1:W] != ext);

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if ((op == CMD_MUL) || ((op == CMD_DIV) && (b != '0))) begin
            state_d  = S_ITER;
            cnt_d    = SHW'(W - 1);
            is_div_d = (op == CMD_DIV);
            sgn_d    = op_signed;
            neg_d    = a_neg ^ b_neg;
            rneg_d   = a_neg;
            hi_d     = '0;
            lo_d     = mag_a;
            mcand_d  = mag_b;
          end else begin
            done_d   = 1'b1;
            res_lo_d = sc_lo;
            res_hi_d = sc_hi;
            flags_d  = {sc_dz, sc_vf, sc_cf, (sc_lo == '0)};
          end
        end
      end

      S_ITER: begin
        if (is_div_q) begin
          // Restoring step: shift in the next dividend bit and subtract if it fits.
          if (div_sh >= {1'b0, mcand_q}) begin
            hi_d = div_diff[W-1:0];
            lo_d = {lo_q[W-2:0], 1'b1};
          end else begin
            hi_d = div_sh[W-1:0];
            lo_d = {lo_q[W-2:0], 1'b0};
          end
        end else begin
          // Shift-add step: conditionally add the multiplicand, then shift the pair right.
          {hi_d, lo_d} = {mul_add, lo_q[W-1:1]};
        end
        if (cnt_q == '0) state_d = S_FIX;
        else             cnt_d   = cnt_q - SHW'(1);
      end

      S_FIX: begin
        state_d = S_IDLE;
        done_d  = 1'b1;
        if (is_div_q) begin
          res_lo_d = quo;
          res_hi_d = rem;
          // Only -2^(W-1) / -1 yields a non-negated quotient with the top bit set.
          flags_d  = {1'b0, (sgn_q & ~neg_q & lo_q[W-1]), 1'b0, (quo == '0)};
        end else begin
          res_lo_d = prod[W-1:0];
          res_hi_d = prod[2*W-1:W];
          flags_d  = {1'b0, ovf, ovf, (prod[W-1:0] == '0)};
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers. A synchronous reset clears everything and aborts any operation.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: sequential state uses non-blocking assignments, so every register samples pre-edge values.
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      is_div_q <= 1'b0;
      sgn_q    <= 1'b0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      mcand_q  <= '0;
      res_lo_q <= '0;
      res_hi_q <= '0;
      flags_q  <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      is_div_q <= is_div_d;
      sgn_q    <= sgn_d;
      neg_q    <= neg_d;
      rneg_q   <= rneg_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      mcand_q  <= mcand_d;
      res_lo_q <= res_lo_d;
      res_hi_q <= res_hi_d;
      flags_q  <= flags_d;
      done_q   <= done_d;
    end
  end

  assign ready  = (state_q == S_IDLE);
  assign done   = done_q;
  assign res_lo = res_lo_q;
  assign res_hi = res_hi_q;
  assign flags  = flags_q;

endmodule

// File: tb/tb_alu_iter.sv
// Scoreboard bench for alu_iter (W=32): a reference model pushes the expected
// results and the due cycle at accept. A monitor pops and compares them on every done.

module tb_alu_iter;

  localparam int W = 32;
  localparam logic [3:0] MOV = 4'd0, ADD = 4'd1, SUB = 4'd2, MUL = 4'd3, DIV = 4'd4,
                         SHR = 4'd5, SHL = 4'd6, XOR = 4'd7, AND = 4'd8, OR  = 4'd9;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [3:0]   op = '0;
  logic         op_signed = 1'b0;
  logic [W-1:0] a = '0, b = '0;
  logic         ready, done;
  logic [W-1:0] res_lo, res_hi;
  logic [3:0]   flags;

  alu_iter #(.W(W), .SHW(5)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .op_signed(op_signed),
    .a(a), .b(b), .ready(ready), .done(done),
    .res_lo(res_lo), .res_hi(res_hi), .flags(flags)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] lo;
    logic [31:0] hi;
    logic [3:0]  flags;
    logic [31:0] due;
    logic [15:0] id;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc   = 0;
  int   n_id  = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model built on wide arithmetic and SV division semantics.
  task automatic model(input logic [3:0] o, input logic s, input logic [31:0] x, input logic [31:0] y,
                       output logic [31:0] lo, output logic [31:0] hi,
                       output logic [3:0] fl, output int lat);
    logic [32:0] sum;
    logic [63:0] p;
    logic [31:0] ext;
    longint sx, sy;
    logic dz, vf, cf;
    lo = '0; hi = '0; dz = 0; vf = 0; cf = 0; lat = 1;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    case (o)
      MOV: begin lo = x; hi = y; end
      ADD: begin
        sum = {1'b0, x} + {1'b0, y};
        lo = sum[31:0]; hi = {31'b0, sum[32]}; cf = sum[32];
        vf = (x[31] == y[31]) && (lo[31] != x[31]);
      end
      SUB: begin
        lo = x - y; cf = (x < y); hi = cf ? 32'hFFFFFFFF : 32'h0;
        vf = (x[31] != y[31]) && (lo[31] != x[31]);
      end
      MUL: begin
        lat = 34;
        if (s) p = 64'(sx * sy);
        else   p = {32'b0, x} * {32'b0, y};
        lo = p[31:0]; hi = p[63:32];
        ext = s ? {32{p[31]}} : 32'h0;
        cf = (hi != ext); vf = cf;
      end
      DIV: begin
        if (y == 0) begin
          lo = 32'hFFFFFFFF; hi = x; dz = 1;
        end else begin
          lat = 34;
          if (s && x == 32'h80000000 && y == 32'hFFFFFFFF) begin
            lo = 32'h80000000; hi = 0; vf = 1;
          end else if (s) begin
            lo = 32'(sx / sy); hi = 32'(sx % sy);
          end else begin
            lo = x / y; hi = x % y;
          end
        end
      end
      SHR: lo = s ? 32'($signed(x) >>> y[4:0]) : (x >> y[4:0]);
      SHL: lo = x << y[4:0];
      XOR: lo = x ^ y;
      AND: lo = x & y;
      OR:  lo = x | y;
      default: begin lo = 0; hi = 0; end
    endcase
    fl = {dz, vf, cf, (lo == 0)};
  endtask

  // Drive one request on the current negedge and register its expected result.
  task automatic drive(input logic [3:0] o, input logic s, input logic [31:0] x, input logic [31:0] y);
    exp_t e;
    int lat;
    start = 1'b1; op = o; op_signed = s; a = x; b = y;
    model(o, s, x, y, e.lo, e.hi, e.flags, lat);
    e.due = 32'(cyc + lat);
    e.id  = 16'(n_id);
    n_id++;
    q.push_back(e);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 60 && q.size() != 0; i++) @(negedge clk);
    if (q.size() != 0) begin
      check("timeout_pending", 64'(q.size()), 64'd0);
      q.delete();
    end
  endtask

  task automatic do_op(input logic [3:0] o, input logic s, input logic [31:0] x, input logic [31:0] y);
    @(negedge clk);
    drive(o, s, x, y);
    @(negedge clk);
    start = 1'b0;
    wait_idle();
  endtask

  // Monitor: every done must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && done) begin
      if (q.size() == 0) begin
        check("spurious_done", 64'd1, 64'd0);
      end else begin
        e = q.pop_front();
        check($sformatf("v%0d.res_lo", e.id), 64'(res_lo), 64'(e.lo));
        check($sformatf("v%0d.res_hi", e.id), 64'(res_hi), 64'(e.hi));
        check($sformatf("v%0d.flags", e.id), 64'(flags), 64'(e.flags));
        check($sformatf("v%0d.latency_cycle", e.id), 64'(cyc), 64'(e.due));
        check($sformatf("v%0d.ready_at_done", e.id), 64'(ready), 64'd1);
      end
    end
  end

  initial begin
    repeat (2) @(negedge clk);
    check("reset.ready", 64'(ready), 64'd1);
    check("reset.done", 64'(done), 64'd0);
    check("reset.res", {res_hi, res_lo}, 64'd0);
    check("reset.flags", 64'(flags), 64'd0);
    rst = 1'b0;

    // Single-cycle ops and their boundary cases.
    do_op(ADD, 0, 32'hFFFFFFFF, 32'h1);
    do_op(ADD, 0, 32'h7FFFFFFF, 32'h1);
    do_op(SUB, 0, 32'd5, 32'd7);
    do_op(SUB, 1, 32'h80000000, 32'd1);
    do_op(MOV, 0, 32'h12345678, 32'h9ABCDEF0);
    do_op(XOR, 0, 32'hF0F0A5A5, 32'h0FF0A5A5);
    do_op(AND, 0, 32'hF0F0A5A5, 32'h0F0F5A5A);
    do_op(OR,  0, 32'hF0000000, 32'h0000000F);
    do_op(SHR, 1, 32'h80000000, 32'h0000003F);
    do_op(SHR, 0, 32'h80000000, 32'd4);
    do_op(SHL, 0, 32'h0000ABCD, 32'd32);
    do_op(SHL, 0, 32'h0000ABCD, 32'd4);
    do_op(4'hF, 0, 32'h1234, 32'h5678);
    do_op(DIV, 0, 32'd100, 32'd0);

    // Iterative ops.
    do_op(MUL, 1, 32'hFFFFFFFD, 32'd7);
    do_op(MUL, 0, 32'hFFFFFFFF, 32'hFFFFFFFF);
    do_op(MUL, 1, 32'h80000000, 32'h80000000);
    do_op(MUL, 1, 32'h00010000, 32'h00010000);
    do_op(DIV, 1, 32'hFFFFFFF9, 32'd2);
    do_op(DIV, 1, 32'd7, 32'hFFFFFFFE);
    do_op(DIV, 1, 32'h80000000, 32'hFFFFFFFF);
    do_op(DIV, 0, 32'd1000, 32'd7);
    do_op(DIV, 0, 32'hFFFFFFFF, 32'd1);

    // Back-to-back single-cycle requests, with start held across done cycles.
    @(negedge clk);
    drive(ADD, 0, 32'd1, 32'd2);
    @(negedge clk);
    drive(SUB, 0, 32'd3, 32'd9);
    @(negedge clk);
    drive(XOR, 0, 32'hFFFF0000, 32'h00FFFF00);
    @(negedge clk);
    drive(DIV, 0, 32'd9, 32'd0);
    @(negedge clk);
    start = 1'b0;
    wait_idle();

    // Start held high during MUL: the requests that follow must be ignored.
    @(negedge clk);
    drive(MUL, 1, 32'hFFFFFFFD, 32'd7);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      op = ADD; a = 32'(i); b = 32'd1;
      if (i == 3) check("busy.ready", 64'(ready), 64'd0);
    end
    start = 1'b0;
    wait_idle();

    // Reset during DIV iteration: no done; outputs return to reset values.
    do_op(MOV, 0, 32'hDEAD, 32'hBEEF);
    @(negedge clk);
    drive(DIV, 0, 32'd1000, 32'd3);
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    q.delete();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort.ready", 64'(ready), 64'd1);
    check("abort.done", 64'(done), 64'd0);
    check("abort.res", {res_hi, res_lo}, 64'd0);
    check("abort.flags", 64'(flags), 64'd0);
    repeat (40) @(negedge clk);

    // Random mix.
    for (int i = 0; i < 24; i++) begin
      logic [3:0]  ro;
      logic [31:0] ra, rb;
      ro = 4'($urandom_range(0, 15));
      ra = $urandom;
      rb = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
      do_op(ro, 1'($urandom_range(0, 1)), ra, rb);
    end

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
